// File: rtl/fifo_bram_rr_arb_if.sv
// Handshake bundle between the round-robin dequeue scheduler, its upstream
// fifo_bram sources and the shared downstream enqueue port.
interface fifo_bram_rr_arb_if #(
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned N_DATA_BITS = 32
);
  localparam int unsigned CHAN_W = $clog2(N_CHANNELS);

  logic [N_CHANNELS-1:0]                  chan_en;
  logic [N_CHANNELS-1:0][N_DATA_BITS-1:0] in_first;
  logic [N_CHANNELS-1:0]                  in_notEmpty;
  logic [N_CHANNELS-1:0]                  in_deq_en;
  logic [N_DATA_BITS-1:0]                 out_data;
  logic [CHAN_W-1:0]                      out_chan;
  logic                                   out_en;
  logic                                   out_almostFull;

  modport master (
    input  chan_en, in_first, in_notEmpty, out_almostFull,
    output in_deq_en, out_data, out_chan, out_en
  );

  modport slave (
    output chan_en, in_first, in_notEmpty, out_almostFull,
    input  in_deq_en, out_data, out_chan, out_en
  );
endinterface

// File: rtl/fifo_bram_rr_arb.sv
// Round-robin burst scheduler: dequeues up to MAX_BURST beats per grant from
// N_CHANNELS upstream FIFOs into one registered, channel-tagged output.
module fifo_bram_rr_arb #(
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned MAX_BURST   = 8
) (
  input logic               clk,
  input logic               reset,
  fifo_bram_rr_arb_if.master bus
);
  localparam int unsigned CHAN_W = $clog2(N_CHANNELS);
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state;
  logic [CHAN_W-1:0]      cur_chan;
  logic [CNT_W-1:0]       beat_cnt;

  logic [N_CHANNELS-1:0]  elig;
  logic                   can_issue;
  logic                   cont;
  logic                   found;
  logic [CHAN_W-1:0]      found_chan;
  logic [CHAN_W-1:0]      cand;
  logic                   grant;
  logic [CHAN_W-1:0]      grant_chan;
  logic [N_CHANNELS-1:0]  deq;

  logic                   out_en_q;
  logic [N_DATA_BITS-1:0] out_data_q;
  logic [CHAN_W-1:0]      out_chan_q;

  assign elig      = bus.in_notEmpty & bus.chan_en;
  assign can_issue = !bus.out_almostFull;
  assign cont      = (state == BURST) && elig[cur_chan] &&
                     (beat_cnt < CNT_W'(MAX_BURST)) && can_issue;

  // Search cur_chan+1 .. cur_chan+N; descending loop lets the nearest hit win,
  // and cur_chan itself is the last candidate.
  always_comb begin
    found      = 1'b0;
    found_chan = cur_chan;
    cand       = cur_chan;
    for (int unsigned i = N_CHANNELS; i >= 1; i--) begin
      cand = CHAN_W'((32'(cur_chan) + 32'(i)) % N_CHANNELS);
      if (elig[cand]) begin
        found      = 1'b1;
        found_chan = cand;
      end
    end
  end

  // Same-cycle grant so a switch or an early-empty channel costs no bubble.
  always_comb begin
    grant      = 1'b0;
    grant_chan = cur_chan;
    if (!reset) begin
      if (cont) begin
        grant = 1'b1;
      end else if (found && can_issue) begin
        grant      = 1'b1;
        grant_chan = found_chan;
      end
    end
    deq = grant ? (N_CHANNELS'(1) << grant_chan) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_chan   <= CHAN_W'(N_CHANNELS - 1);
      beat_cnt   <= '0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
    end else begin
      out_en_q <= grant;
      if (grant) begin
        out_data_q <= bus.in_first[grant_chan];
        out_chan_q <= grant_chan;
      end
      // A stall with an eligible candidate holds everything.
      if (cont) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end else if (!found) begin
        state <= IDLE;
      end else if (can_issue) begin
        state    <= BURST;
        cur_chan <= found_chan;
        beat_cnt <= CNT_W'(1);
      end
    end
  end

  assign bus.in_deq_en = deq;
  assign bus.out_en    = out_en_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_fifo_bram_rr_arb.sv
// Directed and random stimulus for fifo_bram_rr_arb against a queue-based
// model of the upstream FIFOs and the round-robin burst rules.
module tb_fifo_bram_rr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_bram_rr_arb_if #(.N_CHANNELS(N), .N_DATA_BITS(DW)) bus ();

  fifo_bram_rr_arb #(.N_CHANNELS(N), .N_DATA_BITS(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] q [N][$];
  logic [N-1:0]  en;
  logic          af;

  bit            m_burst;
  int            m_cur;
  int            m_cnt;
  logic          exp_en;
  logic [DW-1:0] exp_data;
  logic [CW-1:0] exp_chan;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig(input int c);
    return en[c] && (q[c].size() > 0);
  endfunction

  function automatic int total();
    int t = 0;
    for (int c = 0; c < N; c++) t += q[c].size();
    return t;
  endfunction

  task automatic load(input int c, input int n);
    for (int i = 0; i < n; i++) q[c].push_back($urandom());
  endtask

  task automatic drive();
    bus.chan_en        = en;
    bus.out_almostFull = af;
    for (int c = 0; c < N; c++) begin
      bus.in_notEmpty[c] = (q[c].size() > 0);
      bus.in_first[c]    = (q[c].size() > 0) ? q[c][0] : $urandom();
    end
  endtask

  // One clock: predict the grant, check the strobe, then check the registered output.
  task automatic step();
    int            g;
    int            k;
    int            n_cur;
    int            n_cnt;
    bit            n_burst;
    logic [N-1:0]  exp_deq;
    logic [DW-1:0] hd;
    drive();
    #2;
    g = -1; n_cur = m_cur; n_cnt = m_cnt; n_burst = m_burst; hd = '0;
    if (!reset) begin
      if (m_burst && elig(m_cur) && m_cnt < MB && !af) begin
        g = m_cur;
        n_cnt = m_cnt + 1;
      end else begin
        k = -1;
        for (int i = 1; i <= N; i++)
          if (k < 0 && elig((m_cur + i) % N)) k = (m_cur + i) % N;
        if (k < 0) n_burst = 0;
        else if (!af) begin
          g = k; n_cur = k; n_cnt = 1; n_burst = 1;
        end
      end
    end
    exp_deq = '0;
    if (g >= 0) begin
      exp_deq[g] = 1'b1;
      hd = q[g][0];
    end
    chk("in_deq_en", 64'(bus.in_deq_en), 64'(exp_deq));
    @(posedge clk);
    #1;
    if (reset) begin
      m_burst = 0; m_cur = N - 1; m_cnt = 0;
      exp_en = 1'b0; exp_data = '0; exp_chan = '0;
    end else begin
      m_burst = n_burst; m_cur = n_cur; m_cnt = n_cnt;
      exp_en = (g >= 0);
      if (g >= 0) begin
        exp_data = hd;
        exp_chan = CW'(g);
        void'(q[g].pop_front());
      end
    end
    chk("out_en", 64'(bus.out_en), 64'(exp_en));
    chk("out_data", 64'(bus.out_data), 64'(exp_data));
    chk("out_chan", 64'(bus.out_chan), 64'(exp_chan));
  endtask

  task automatic peek(input string tag, input logic [N-1:0] exp);
    drive();
    #2;
    chk(tag, 64'(bus.in_deq_en), 64'(exp));
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int b = budget;
    while (total() > 0 && b > 0) begin
      step();
      b--;
    end
    chk(tag, 64'(total()), 64'(0));
  endtask

  initial begin
    reset = 1'b1; en = '1; af = 1'b0;
    m_burst = 0; m_cur = N - 1; m_cnt = 0;
    exp_en = 1'b0; exp_data = '0; exp_chan = '0;
    step();
    step();
    chk("rst_out_en", 64'(bus.out_en), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_chan", 64'(bus.out_chan), 64'(0));
    reset = 1'b0;

    // Single channel: five beats, re-grant after MAX_BURST without a gap.
    load(2, 5);
    peek("single_first", 4'b0100);
    for (int i = 0; i < 5; i++) step();
    peek("single_done", 4'b0000);
    step();
    step();

    // Full rotation across four loaded channels.
    reset_pulse();
    for (int c = 0; c < N; c++) load(c, 10);
    drain("rotation_drain", 60);
    step();

    // Stall after ch0's second beat, resume on ch0, then ch1.
    reset_pulse();
    load(0, 8);
    load(1, 8);
    step();
    step();
    af = 1'b1;
    for (int i = 0; i < 3; i++) step();
    af = 1'b0;
    peek("stall_resume", 4'b0001);
    step();
    step();
    peek("stall_next", 4'b0010);
    drain("stall_drain", 40);

    // Early empty: ch1 runs dry after two beats, ch2 follows immediately.
    reset_pulse();
    load(1, 2);
    load(2, 6);
    step();
    step();
    peek("early_switch", 4'b0100);
    drain("early_drain", 30);
    step();

    // Masking: ch2 never granted; dropping chan_en[1] ends ch1's burst at once.
    reset_pulse();
    en = 4'b1011;
    for (int c = 0; c < N; c++) load(c, 6);
    for (int i = 0; i < 6; i++) step();
    en = 4'b1001;
    peek("mask_drop", 4'b1000);
    for (int i = 0; i < 10; i++) step();
    en = '1;
    drain("mask_drain", 60);

    // Reset mid-burst on ch1; next grant restarts at ch0.
    reset_pulse();
    load(1, 6);
    step();
    step();
    reset = 1'b1;
    peek("rst_no_deq", 4'b0000);
    step();
    reset = 1'b0;
    chk("rst_out_en_after", 64'(bus.out_en), 64'(0));
    load(0, 3);
    peek("rst_regrant", 4'b0001);
    drain("rst_drain", 30);

    // Random traffic, back-pressure, masks and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        int c = $urandom_range(0, N - 1);
        if (q[c].size() < 12) q[c].push_back($urandom());
      end
      af = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) en = N'($urandom());
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; af = 1'b0; en = '1;
    drain("random_drain", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
